// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants, state encodings and helpers for the
// multi-cycle 32-bit divider (div_unit, div_iter, div_unit_if).
package div_unit_pkg;

    localparam int DataBus      = 32;
    localparam int DoubleRegBus = 64;
    localparam int WorkBus      = 65;

    localparam logic [DataBus-1:0] ZeroWord = 32'h0000_0000;

    // FSM state encodings (kept as plain constants for legacy decode logic)
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Number of restoring steps for a full-width divide
    localparam logic [5:0] DivSteps = 6'd32;

    // Sign bookkeeping captured when an operation is accepted
    typedef struct packed {
        logic is_signed;
        logic dividend_neg;
        logic divisor_neg;
    } div_sign_t;

    // Two's-complement negate when neg is set; 0x80000000 maps onto itself,
    // which is exactly the unsigned magnitude we want for abs().
    function automatic logic [DataBus-1:0] cond_negate(input logic [DataBus-1:0] v,
                                                       input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: divide handshake between the execute stage (master) and
// the divider (slave).
interface div_unit_if;
    import div_unit_pkg::*;

    logic                    start_i;
    logic                    annul_i;
    logic                    signed_i;
    logic [DataBus-1:0]      opdata1_i;
    logic [DataBus-1:0]      opdata2_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit_iter.sv
// div_iter: one combinational restoring shift-subtract step.
// rem_i is the 33-bit partial remainder, quo_i the quotient bits gathered so
// far (its MSB is shifted out and never needed), dbit_i the next dividend bit.
module div_iter
    import div_unit_pkg::*;
(
    input  logic [32:0]         rem_i,
    input  logic [30:0]         quo_i,
    input  logic                dbit_i,
    input  logic [DataBus-1:0]  divisor_i,
    output logic [WorkBus-1:0]  work_o
);

    logic [32:0] cand;
    logic [32:0] diff;
    logic        ge;

    // Shift in the next dividend bit, compare against {0,divisor} and restore
    // when the subtraction would go negative. A set bit shifted out of the
    // remainder means the candidate is certainly large enough.
    always_comb begin
        cand   = {rem_i[31:0], dbit_i};
        ge     = rem_i[32] | (cand >= {1'b0, divisor_i});
        diff   = cand - {1'b0, divisor_i};
        work_o = {(ge ? diff : cand), quo_i, ge};
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit signed/unsigned divider, result
// {remainder, quotient}. Optional macro DIV_EARLY_EXIT_EN: when
// |dividend| < |divisor| the result is produced without iterating.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DivFree   | idle, waiting for start_i
// DivByZero | divisor was zero, result 0 is posted on the next edge
// DivOn     | 32 restoring steps, then sign fix-up and result register
// DivEnd    | result valid, held while start_i stays high
module div_unit
    import div_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    logic [1:0]          state;
    logic [5:0]          cnt;
    logic [DataBus-1:0]  dividend_r;
    logic [DataBus-1:0]  divisor_r;
    logic [WorkBus-1:0]  work;
    logic [WorkBus-1:0]  work_nxt;
    div_sign_t           sign_r;

    logic                op1_neg;
    logic                op2_neg;
    logic [DataBus-1:0]  abs_op1;
    logic [DataBus-1:0]  abs_op2;
    logic [DataBus-1:0]  quo_fix;
    logic [DataBus-1:0]  rem_fix;

    // Operand magnitudes; only taken as negative for DIV with bit31 set
    always_comb begin
        op1_neg = bus.signed_i & bus.opdata1_i[31];
        op2_neg = bus.signed_i & bus.opdata2_i[31];
        abs_op1 = cond_negate(bus.opdata1_i, op1_neg);
        abs_op2 = cond_negate(bus.opdata2_i, op2_neg);
    end

    div_iter u_iter (
        .rem_i     (work[64:32]),
        .quo_i     (work[30:0]),
        .dbit_i    (dividend_r[31]),
        .divisor_i (divisor_r),
        .work_o    (work_nxt)
    );

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend
    always_comb begin
        quo_fix = cond_negate(work[31:0],
                              sign_r.is_signed & (sign_r.dividend_neg ^ sign_r.divisor_neg));
        rem_fix = cond_negate(work[63:32], sign_r.dividend_neg);
    end

    // Divider FSM, step counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DivFree;
            cnt          <= 6'd0;
            dividend_r   <= ZeroWord;
            divisor_r    <= ZeroWord;
            work         <= '0;
            sign_r       <= '0;
            bus.ready_o  <= DivResultNotReady;
            bus.result_o <= '0;
        end else begin
            case (state)
                DivFree: begin
                    bus.ready_o  <= DivResultNotReady;
                    bus.result_o <= '0;
                    if (bus.start_i == DivStart && !bus.annul_i) begin
                        if (bus.opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end
`ifdef DIV_EARLY_EXIT_EN
                        else if (abs_op1 < abs_op2) begin
                            // quotient 0, remainder is the dividend untouched
                            state        <= DivEnd;
                            bus.result_o <= {bus.opdata1_i, ZeroWord};
                        end
`endif
                        else begin
                            dividend_r <= abs_op1;
                            divisor_r  <= abs_op2;
                            sign_r     <= '{is_signed:    bus.signed_i,
                                            dividend_neg: op1_neg,
                                            divisor_neg:  op2_neg};
                            work       <= '0;
                            cnt        <= 6'd0;
                            state      <= DivOn;
                        end
                    end
                end

                DivByZero: begin
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state        <= DivFree;
                        bus.ready_o  <= DivResultNotReady;
                        bus.result_o <= '0;
                    end else begin
                        state        <= DivEnd;
                        bus.ready_o  <= DivResultReady;
                        bus.result_o <= '0;
                    end
                end

                DivOn: begin
                    if (bus.annul_i || bus.start_i == DivStop) begin
                        state        <= DivFree;
                        cnt          <= 6'd0;
                        bus.ready_o  <= DivResultNotReady;
                        bus.result_o <= '0;
                    end else if (cnt != DivSteps) begin
                        work       <= work_nxt;
                        dividend_r <= {dividend_r[30:0], 1'b0};
                        cnt        <= cnt + 6'd1;
                    end else begin
                        state        <= DivEnd;
                        cnt          <= 6'd0;
                        bus.ready_o  <= DivResultReady;
                        bus.result_o <= {rem_fix, quo_fix};
                    end
                end

                DivEnd: begin
                    // annul_i is ignored here: the result is already complete
                    if (bus.start_i == DivStart) begin
                        bus.ready_o <= DivResultReady;
                    end else begin
                        state        <= DivFree;
                        bus.ready_o  <= DivResultNotReady;
                        bus.result_o <= '0;
                    end
                end

                default: begin
                    state        <= DivFree;
                    bus.ready_o  <= DivResultNotReady;
                    bus.result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider: the responder side of the execute stage's divide handshake. Accepts signed/unsigned DIV/DIVU operands on start, runs a 32-step restoring shift-subtract sequence, and returns {remainder, quotient} with a ready flag. The execute stage stalls the pipeline while ready is low and writes HI/LO from the result.

## Interface
- No parameters; data width fixed at 32 (`DataBus`).
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  request; held high by EX until ready_o seen
- annul_i  in  1  abort in-flight divide (pipeline flush)
- signed_i  in  1  1 = DIV, 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid

## Operation
- States: FREE, BYZERO, ON, END. Reset: FREE, ready_o=0, result_o=0, counter=0.
- FREE: start_i=1 & annul_i=0: divisor==0 → BYZERO; else latch |dividend|, |divisor| (abs only when signed_i=1 and operand bit31=1), latch signed_i and operand signs, clear 65-bit work register, cnt=0 → ON.
- BYZERO: → END, result 0.
- ON, cnt<32: one restoring step per cycle: shift work left 1 bringing in next dividend bit; if upper 33 bits ≥ {0,divisor} subtract and set quotient bit 1 else 0; cnt++.
- ON, cnt==32: sign fix (signed only): quotient negated if dividend sign ≠ divisor sign; remainder takes dividend sign (negated if dividend negative). Register result_o, ready_o=1 → END.
- ON, annul_i=1 or start_i=0: → FREE, ready_o=0, result_o=0; no result produced.
- END: ready_o=1, result_o held while start_i=1. start_i=0 → FREE, ready_o=0, result_o=0.
- Operands sampled only on FREE→ON; later changes on opdata*_i ignored.
- Signed 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0; no exception.
- Arithmetic is modulo 2^32; abs(0x80000000) treated as unsigned 0x80000000.

## Timing
- Edge 0: start accepted in FREE. Edges 1–32: iterations. Edge 33: sign fix, ready_o=1. Latency 34 cycles start→ready.
- Divide by zero: ready_o high after edge 1 (latency 2).
- ready_o falls one cycle after start_i deasserts in END; a new start may be accepted the cycle after that (FREE).
- annul_i has priority over start_i in every state except END; in END annul_i is ignored (result already complete).
- rst mid-operation: FREE, outputs zero next edge, regardless of state.
- All outputs registered; no combinational path input→output.

## Configuration
- DIV_EARLY_EXIT_EN defined: in FREE, if |dividend| < |divisor| (divisor≠0), go directly to END with quotient 0, remainder = original dividend; latency 2.
- Undefined: all non-zero-divisor cases take the full 34-cycle path; results identical.

## Structure
- Shared defines/package: state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/Stop, `ZeroWord`, 64-bit result width.
- Sub-module div_iter: combinational single step (33-bit compare/subtract, next work register, quotient bit). div_unit owns FSM, counter, sign handling.

## Test plan
- Unsigned 100/7 → result_o 0x00000002_0000000E, ready_o rises exactly 34 cycles after start.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same as DIVU gives 0x00000001_7FFFFFFC.
- Divisor 0 → result 0, ready in 2 cycles; 0x80000000/0xFFFFFFFF signed → 0x00000000_80000000.
- annul_i pulse at cycle 10 of ON → FREE, ready_o never asserts; next start 20/3 → 0x00000002_00000006.
- Hold start_i 5 cycles in END → ready_o/result_o stable; drop start → ready_o=0 next cycle; rst asserted mid-ON → all outputs 0 next edge.
- With DIV_EARLY_EXIT_EN: 3/10 unsigned → 0x00000003_00000000 in 2 cycles; without it, 34 cycles, same value.
